// File: rtl/count_seq_pkg.sv
// Shared types and constants for the FND count sequencer.
// No logic: the state encoding, count width and default wrap value.
package count_seq_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      RUN   = 2'd1,
      CLEAR = 2'd2
   } state_t;

   localparam int COUNT_W       = 14;
   localparam int DEF_MAX_COUNT = 9999;

endpackage

// File: rtl/btn_edge_detect.sv
// One button: 2-FF synchronizer plus a rising-edge pulse, one cycle wide per press.
// Event is visible two edges after the level is first captured; no backpressure.
module btn_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_edge
);

   logic r_sync1;
   logic r_sync2;
   logic r_dly;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_dly   <= 1'b0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
         r_dly   <= r_sync2;
      end
   end

   assign btn_edge = r_sync2 & ~r_dly;

endmodule

// File: rtl/count_sequencer.sv
// Run/stop/clear sequencer producing a 0..MAX_COUNT value for the FND display.
// State/mode update two edges after a button is captured; count steps every DIV cycles in RUN.
module count_sequencer
   import count_seq_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 10,
   parameter int MAX_COUNT = DEF_MAX_COUNT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               btn_run_stop,
   input  logic               btn_clear,
   input  logic               btn_mode,
   output logic [COUNT_W-1:0] count_data,
   output logic               running,
   output logic               mode_down,
   output logic               tick
);

   localparam int                 DIV      = CLK_HZ / TICK_HZ;
   localparam int                 DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
   localparam logic [COUNT_W-1:0] MAX_C    = COUNT_W'(MAX_COUNT);
   localparam logic [COUNT_W-1:0] ONE_C    = COUNT_W'(1);

   logic               w_ev_rs;
   logic               w_ev_clr;
   logic               w_ev_mode;
   state_t             r_state;
   state_t             w_state_nxt;
   logic [DIV_W-1:0]   r_div;
   logic               r_mode_down;
   logic [COUNT_W-1:0] r_count;
   logic [COUNT_W-1:0] w_count_step;

   btn_edge_detect u_rs  (.clk(clk), .reset(reset), .btn_in(btn_run_stop), .btn_edge(w_ev_rs));
   btn_edge_detect u_clr (.clk(clk), .reset(reset), .btn_in(btn_clear),    .btn_edge(w_ev_clr));
   btn_edge_detect u_md  (.clk(clk), .reset(reset), .btn_in(btn_mode),     .btn_edge(w_ev_mode));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= STOP;
      else       r_state <= w_state_nxt;
   end

   // run_stop has priority over clear when both land in STOP together
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         STOP: begin
            if (w_ev_rs)       w_state_nxt = RUN;
            else if (w_ev_clr) w_state_nxt = CLEAR;
         end
         RUN:     if (w_ev_rs) w_state_nxt = STOP;
         CLEAR:   w_state_nxt = STOP;
         default: w_state_nxt = STOP;
      endcase
   end

   always_comb begin
      running = (r_state == RUN);
      tick    = (r_state == RUN) && (r_div == DIV_LAST);
   end

   // Leaving RUN zeroes the divider so a restart always gets a full period
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div <= '0;
      end else if (r_state == RUN && w_state_nxt == RUN) begin
         r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_ONE;
      end else begin
         r_div <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_mode_down <= 1'b0;
      else if (w_ev_mode) r_mode_down <= ~r_mode_down;
   end

   always_comb begin
      if (r_mode_down) w_count_step = (r_count == '0)    ? MAX_C : r_count - ONE_C;
      else             w_count_step = (r_count >= MAX_C) ? '0    : r_count + ONE_C;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                     r_count <= '0;
      else if (w_state_nxt == CLEAR) r_count <= '0;
      else if (tick)                 r_count <= w_count_step;
   end

   assign count_data = r_count;
   assign mode_down  = r_mode_down;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed plus random stimulus on two sequencers (default wrap and wrap-at-3),
// compared every cycle against an event-level reference model.
module tb_count_sequencer;

   localparam int CLK_HZ  = 100;
   localparam int TICK_HZ = 10;
   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int MAX_A   = 9999;
   localparam int MAX_B   = 3;
   localparam int M_STOP  = 0;
   localparam int M_RUN   = 1;
   localparam int M_CLEAR = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        btn_rs, btn_clr, btn_md;
   logic [13:0] cnt_a, cnt_b;
   logic        run_a, run_b, md_a, md_b, tk_a, tk_b;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_state, m_run_cyc, m_cnt_a, m_cnt_b, edge_no;
   bit m_mode, prev_rs, prev_clr, prev_md;
   int q_rs[$], q_clr[$], q_md[$];

   always #5 clk = ~clk;

   count_sequencer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut_a (
      .clk(clk), .reset(reset), .btn_run_stop(btn_rs), .btn_clear(btn_clr), .btn_mode(btn_md),
      .count_data(cnt_a), .running(run_a), .mode_down(md_a), .tick(tk_a)
   );

   count_sequencer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_COUNT(MAX_B)) dut_b (
      .clk(clk), .reset(reset), .btn_run_stop(btn_rs), .btn_clear(btn_clr), .btn_mode(btn_md),
      .count_data(cnt_b), .running(run_b), .mode_down(md_b), .tick(tk_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int step_cnt(input int c, input int mx, input bit down);
      if (down) return (c == 0) ? mx : c - 1;
      return (c == mx) ? 0 : c + 1;
   endfunction

   function automatic bit model_tick();
      return (m_state == M_RUN) && ((m_run_cyc % DIV) == DIV - 1);
   endfunction

   task automatic model_reset();
      m_state = M_STOP; m_run_cyc = 0; m_cnt_a = 0; m_cnt_b = 0; m_mode = 1'b0;
      prev_rs = 1'b0; prev_clr = 1'b0; prev_md = 1'b0;
      q_rs.delete(); q_clr.delete(); q_md.delete();
   endtask

   // A press seen at edge N becomes an event acted on at edge N+2
   task automatic model_edge();
      bit ev_rs, ev_clr, ev_md, tk;
      edge_no++;
      if (reset) begin
         model_reset();
         return;
      end
      ev_rs  = (q_rs.size()  > 0 && q_rs[0]  == edge_no);
      ev_clr = (q_clr.size() > 0 && q_clr[0] == edge_no);
      ev_md  = (q_md.size()  > 0 && q_md[0]  == edge_no);
      if (ev_rs)  void'(q_rs.pop_front());
      if (ev_clr) void'(q_clr.pop_front());
      if (ev_md)  void'(q_md.pop_front());
      if (btn_rs  && !prev_rs)  q_rs.push_back(edge_no + 2);
      if (btn_clr && !prev_clr) q_clr.push_back(edge_no + 2);
      if (btn_md  && !prev_md)  q_md.push_back(edge_no + 2);
      prev_rs = btn_rs; prev_clr = btn_clr; prev_md = btn_md;

      tk = model_tick();
      if (tk) begin
         m_cnt_a = step_cnt(m_cnt_a, MAX_A, m_mode);
         m_cnt_b = step_cnt(m_cnt_b, MAX_B, m_mode);
      end
      if (ev_md) m_mode = !m_mode;
      case (m_state)
         M_STOP: begin
            if (ev_rs) begin
               m_state = M_RUN; m_run_cyc = 0;
            end else if (ev_clr) begin
               m_state = M_CLEAR; m_cnt_a = 0; m_cnt_b = 0;
            end
         end
         M_RUN: begin
            if (ev_rs) m_state = M_STOP;
            else       m_run_cyc++;
         end
         default: m_state = M_STOP;
      endcase
   endtask

   task automatic check_outputs();
      logic [16:0] e_a, e_b;
      bit r, t;
      r   = (m_state == M_RUN);
      t   = model_tick();
      e_a = {r, m_mode, t, 14'(m_cnt_a)};
      e_b = {r, m_mode, t, 14'(m_cnt_b)};
      chk("outs_a{run,mode,tick,count}", {15'd0, run_a, md_a, tk_a, cnt_a}, {15'd0, e_a});
      chk("outs_b{run,mode,tick,count}", {15'd0, run_b, md_b, tk_b, cnt_b}, {15'd0, e_b});
   endtask

   // Called at a negedge: check, drive the next levels, advance one edge
   task automatic cyc(input bit rs, input bit cl, input bit md);
      check_outputs();
      btn_rs = rs; btn_clr = cl; btn_md = md;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic wait_cnt_a(input string tag, input int target, input int limit);
      int n;
      n = 0;
      while (cnt_a !== 14'(target) && n < limit) begin
         cyc(1'b0, 1'b0, 1'b0);
         n++;
      end
      chk(tag, {18'd0, cnt_a}, target);
   endtask

   initial begin
      int hold;
      bit r_lvl, c_lvl, m_lvl;
      edge_no = 0;
      reset = 1'b1; btn_rs = 1'b0; btn_clr = 1'b0; btn_md = 1'b0;
      model_reset();
      @(negedge clk);
      idle(3);
      chk("reset_state", {14'd0, run_a, md_a, tk_a, cnt_a}, 32'd0);
      reset = 1'b0;
      idle(2);

      // start: running two edges after capture, first tick in the 10th RUN cycle
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("run_not_yet", {31'd0, run_a}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("start_running", {31'd0, run_a}, 32'd1);
      idle(9);
      chk("first_tick", {31'd0, tk_a}, 32'd1);
      chk("count_before_tick", {18'd0, cnt_a}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("first_count", {18'd0, cnt_a}, 32'd1);
      idle(50);
      chk("count_after_50", {18'd0, cnt_a}, 32'd6);
      chk("wrap3_after_50", {18'd0, cnt_b}, 32'd2);

      // clear is ignored while running
      wait_cnt_a("reach_7", 7, 40);
      cyc(1'b0, 1'b1, 1'b0);
      idle(20);
      chk("clear_in_run_ignored", {31'd0, run_a}, 32'd1);

      // stop, hold, then clear
      cyc(1'b1, 1'b0, 1'b0);
      idle(4);
      chk("stopped", {31'd0, run_a}, 32'd0);
      idle(20);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("clear_count", {18'd0, cnt_a}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("after_clear_stop", {31'd0, run_a}, 32'd0);

      // run_stop and clear together from STOP: run wins, count kept
      cyc(1'b1, 1'b0, 1'b0);
      wait_cnt_a("reach_2", 2, 40);
      cyc(1'b1, 1'b0, 1'b0);
      idle(4);
      cyc(1'b1, 1'b1, 1'b0);
      idle(3);
      chk("both_run", {31'd0, run_a}, 32'd1);
      chk("both_count_kept", {18'd0, cnt_a}, 32'd2);

      // held button gives one transition only
      for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b0);
      idle(5);
      chk("hold_one_transition", {31'd0, run_a}, 32'd0);

      // stop at divider 5, restart gets a full period
      cyc(1'b1, 1'b0, 1'b0);
      idle(2);
      idle(3);
      cyc(1'b1, 1'b0, 1'b0);
      idle(3);
      cyc(1'b1, 1'b0, 1'b0);
      idle(2);
      chk("restart_running", {31'd0, run_a}, 32'd1);
      idle(9);
      chk("restart_full_period_tick", {31'd0, tk_a}, 32'd1);
      cyc(1'b0, 1'b0, 1'b0);

      // mode toggle mid-run at count 4
      cyc(1'b1, 1'b0, 1'b0);
      idle(4);
      cyc(1'b0, 1'b1, 1'b0);
      idle(4);
      cyc(1'b1, 1'b0, 1'b0);
      wait_cnt_a("reach_4", 4, 60);
      cyc(1'b0, 1'b0, 1'b1);
      idle(3);
      chk("mode_down_set", {31'd0, md_a}, 32'd1);
      wait_cnt_a("down_to_3", 3, 20);

      // down wrap, then up wrap
      wait_cnt_a("down_to_0", 0, 50);
      wait_cnt_a("down_wrap", MAX_A, 15);
      cyc(1'b0, 1'b0, 1'b1);
      wait_cnt_a("up_wrap", 0, 15);

      // reset mid-run clears everything at once
      idle(3);
      reset = 1'b1;
      #1;
      model_reset();
      chk("reset_mid_run", {14'd0, run_a, md_a, tk_a, cnt_a}, 32'd0);
      @(negedge clk);
      idle(2);
      reset = 1'b0;
      idle(40);
      chk("no_tick_after_reset", {18'd0, cnt_a}, 32'd0);

      // random button activity against the model
      for (int s = 0; s < 80; s++) begin
         r_lvl = ($urandom_range(0, 3) == 0);
         c_lvl = ($urandom_range(0, 4) == 0);
         m_lvl = ($urandom_range(0, 5) == 0);
         hold  = $urandom_range(1, 12);
         for (int i = 0; i < hold; i++) cyc(r_lvl, c_lvl, m_lvl);
      end
      idle(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
